// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and registered result/flags.
// Logic/arith/move ops finish in one cycle; shifts iterate one bit per cycle; MUL is shift-add.
module seq_alu #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IMM_W = 3,
   parameter int unsigned SHW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             imm_en,
   input  logic [IMM_W-1:0] imm,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       szcv,
   output logic             res_we,
   output logic             err
);

   localparam int unsigned CW = SHW + 1;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b0101;
   localparam logic [3:0] OP_MOV = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_ROL = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;
   localparam logic [3:0] OP_SRA = 4'b1011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] lo, lo_d;
   logic [WIDTH-1:0] hi, hi_d;
   logic [WIDTH-1:0] mcand, mcand_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [WIDTH-1:0] result_d;
   logic [3:0]       szcv_d;
   logic             res_we_d, err_d;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_add, sum_sub;
   logic [WIDTH-1:0] q_res;
   logic             q_c, q_v, q_we, q_err;

   logic [WIDTH:0]   madd;
   logic [WIDTH-1:0] s_lo, s_hi;
   logic             s_c;
   logic             accept;

   // Single-cycle results, evaluated on the live inputs for the accept edge
   always_comb begin
      b_eff   = (imm_en && (op <= OP_MOV)) ? WIDTH'(imm) : b;
      sum_add = {1'b0, a} + {1'b0, b_eff};
      sum_sub = {1'b0, a} + {1'b0, ~b_eff} + {{WIDTH{1'b0}}, 1'b1};
      q_res   = '0;
      q_c     = 1'b0;
      q_v     = 1'b0;
      q_we    = 1'b1;
      q_err   = 1'b0;
      case (op)
         OP_ADD: begin
            q_res = sum_add[WIDTH-1:0];
            q_c   = sum_add[WIDTH];
            q_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (q_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            q_res = sum_sub[WIDTH-1:0];
            q_c   = sum_sub[WIDTH];
            q_v   = (a[WIDTH-1] != b_eff[WIDTH-1]) && (q_res[WIDTH-1] != a[WIDTH-1]);
            q_we  = (op != OP_CMP);
         end
         OP_AND: q_res = a & b_eff;
         OP_OR:  q_res = a | b_eff;
         OP_XOR: q_res = a ^ b_eff;
         OP_MOV: q_res = b_eff;
         OP_MUL: q_res = '0;
         OP_SLL, OP_ROL, OP_SRL, OP_SRA: q_res = a;
         default: begin
            q_err = 1'b1;
            q_we  = 1'b0;
         end
      endcase
   end

   // One iteration of the latched shift/rotate or multiply
   always_comb begin
      s_lo = lo;
      s_hi = hi;
      s_c  = 1'b0;
      madd = '0;
      case (op_q)
         OP_SLL: begin
            s_c  = lo[WIDTH-1];
            s_lo = {lo[WIDTH-2:0], 1'b0};
         end
         OP_ROL: s_lo = {lo[WIDTH-2:0], lo[WIDTH-1]};
         OP_SRL: begin
            s_c  = lo[0];
            s_lo = {1'b0, lo[WIDTH-1:1]};
         end
         OP_SRA: begin
            s_c  = lo[0];
            s_lo = {lo[WIDTH-1], lo[WIDTH-1:1]};
         end
         OP_MUL: begin
            madd         = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
            {s_hi, s_lo} = {madd, lo[WIDTH-1:1]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         op_q   <= '0;
         lo     <= '0;
         hi     <= '0;
         mcand  <= '0;
         cnt    <= '0;
         result <= '0;
         szcv   <= '0;
         res_we <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_d;
         op_q   <= op_d;
         lo     <= lo_d;
         hi     <= hi_d;
         mcand  <= mcand_d;
         cnt    <= cnt_d;
         result <= result_d;
         szcv   <= szcv_d;
         res_we <= res_we_d;
         err    <= err_d;
      end
   end

   assign out_valid = (state == DONE);

   always_comb begin
      state_d  = state;
      op_d     = op_q;
      lo_d     = lo;
      hi_d     = hi;
      mcand_d  = mcand;
      cnt_d    = cnt;
      result_d = result;
      szcv_d   = szcv;
      res_we_d = res_we;
      err_d    = err;
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
      accept   = in_valid && in_ready;

      case (state)
         BUSY: begin
            lo_d  = s_lo;
            hi_d  = s_hi;
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_d  = DONE;
               result_d = s_lo;
               szcv_d   = {s_lo[WIDTH-1], (s_lo == '0), (op_q == OP_MUL) ? (|s_hi) : s_c, 1'b0};
               res_we_d = 1'b1;
               err_d    = 1'b0;
            end
         end
         DONE: if (out_ready && !in_valid) state_d = IDLE;
         default: ;
      endcase

      // A new request (from IDLE, or back-to-back out of DONE) overrides the above
      if (accept) begin
         op_d    = op;
         lo_d    = a;
         hi_d    = '0;
         mcand_d = b;
         if (op == OP_MUL) begin
            state_d = BUSY;
            cnt_d   = CW'(WIDTH);
         end else if ((op[3:2] == 2'b10) && (shamt != '0)) begin
            state_d = BUSY;
            cnt_d   = CW'(shamt);
         end else begin
            state_d  = DONE;
            result_d = q_res;
            szcv_d   = {q_res[WIDTH-1], (q_res == '0), q_c, q_v};
            res_we_d = q_we;
            err_d    = q_err;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: arithmetic reference model, per-cycle compare, directed and random stimulus.
`timescale 1ns/1ps
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic        imm_en;
   logic [2:0]  imm;
   logic [3:0]  shamt;
   logic        out_valid;
   wire         out_ready;
   logic [15:0] result;
   logic [3:0]  szcv;
   logic        res_we, err;

   logic ready_val  = 1'b1;
   logic ready_rand = 1'b0;
   logic rnd_ready  = 1'b1;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  szcv;
      logic        we;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   exp_t ne;
   exp_t pm;
   logic due;

   seq_alu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .imm_en(imm_en), .imm(imm), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .szcv(szcv), .res_we(res_we), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;
   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end
   assign out_ready = ready_rand ? rnd_ready : ready_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference: arithmetic on integers straight from the op definitions
   function automatic exp_t model(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                                  input logic ie, input logic [2:0] im, input logic [3:0] sh);
      exp_t   e;
      int     ua, ub, sa, sb, r, c, v, d;
      longint p;
      ua = int'(xa);
      ub = (ie && (o <= 4'd6)) ? int'(im) : int'(xb);
      sa = int'($signed(xa));
      sb = (ub >= 32768) ? ub - 65536 : ub;
      d  = int'(sh);
      r = 0; c = 0; v = 0;
      e.we = 1'b1; e.err = 1'b0; e.lat = 1; e.acc = 0;
      case (o)
         4'd0: begin
            r = ua + ub; c = (r > 65535) ? 1 : 0;
            v = ((sa + sb > 32767) || (sa + sb < -32768)) ? 1 : 0;
         end
         4'd1, 4'd5: begin
            r = ua - ub; c = (ua >= ub) ? 1 : 0;
            v = ((sa - sb > 32767) || (sa - sb < -32768)) ? 1 : 0;
            if (o == 4'd5) e.we = 1'b0;
         end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd6: r = ub;
         4'd7: begin
            p = longint'(ua) * longint'(ub);
            r = int'(p & 64'hFFFF);
            c = ((p >> 16) != 0) ? 1 : 0;
            e.lat = 17;
         end
         4'd8: begin
            r = ua << d; c = (d > 0) ? ((ua >> (16 - d)) & 1) : 0; e.lat = d + 1;
         end
         4'd9: begin
            r = (ua << d) | (ua >> (16 - d)); e.lat = d + 1;
         end
         4'd10: begin
            r = ua >> d; c = (d > 0) ? ((ua >> (d - 1)) & 1) : 0; e.lat = d + 1;
         end
         4'd11: begin
            r = sa >>> d; c = (d > 0) ? ((ua >> (d - 1)) & 1) : 0; e.lat = d + 1;
         end
         default: begin
            r = 0; e.err = 1'b1; e.we = 1'b0;
         end
      endcase
      e.res  = 16'(r & 32'hFFFF);
      e.szcv = {e.res[15], (e.res == 16'h0), c[0], v[0]};
      return e;
   endfunction

   // Per-cycle compare against the model queue
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
      end else begin
         due = (q.size() != 0) && (cycle - q[0].acc >= q[0].lat);
         check("out_valid", 32'(out_valid), 32'(due));
         check("in_ready", 32'(in_ready), 32'((q.size() == 0) || (due && out_ready)));
         if (due && out_valid) begin
            check("result", 32'(result), 32'(q[0].res));
            check("szcv", 32'(szcv), 32'(q[0].szcv));
            check("res_we", 32'(res_we), 32'(q[0].we));
            check("err", 32'(err), 32'(q[0].err));
         end
         if (due && out_ready) void'(q.pop_front());
         if (in_valid && in_ready) begin
            ne = model(op, a, b, imm_en, imm, shamt);
            ne.acc = cycle;
            q.push_back(ne);
         end
      end
   end

   task automatic send(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                       input logic ie, input logic [2:0] im, input logic [3:0] sh, output int acc);
      bit ok;
      ok = 1'b0;
      acc = 0;
      op = o; a = xa; b = xb; imm_en = ie; imm = im; shamt = sh; in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            acc = cycle;
         end
      end
      check("accept_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input int acc, input int lat, input logic [15:0] er,
                             input logic [3:0] es, input logic ew, input logic ee);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check({name, "_seen"}, 32'(seen), 32'd1);
      check({name, "_lat"}, 32'(cycle - acc), 32'(lat));
      check({name, "_res"}, 32'(result), 32'(er));
      check({name, "_szcv"}, 32'(szcv), 32'(es));
      check({name, "_we"}, 32'(res_we), 32'(ew));
      check({name, "_err"}, 32'(err), 32'(ee));
      @(posedge clk); #1;
   endtask

   initial begin
      int acc;
      logic [3:0]  ro;
      logic [15:0] ra;
      rst = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; imm_en = 1'b0; imm = '0; shamt = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_result", 32'(result), 32'd0);
      check("rst_szcv", 32'(szcv), 32'd0);
      check("rst_res_we", 32'(res_we), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b1;

      // Pin the model with hand-computed values
      pm = model(4'd0, 16'h7FFF, 16'h0001, 1'b0, 3'd0, 4'd0);
      check("model_add", {pm.res, 12'h0, pm.szcv}, {16'h8000, 12'h0, 4'b1001});
      pm = model(4'd11, 16'h8001, 16'h0, 1'b0, 3'd0, 4'd1);
      check("model_sra", {pm.res, 12'h0, pm.szcv}, {16'hC000, 12'h0, 4'b1010});
      pm = model(4'd8, 16'h8001, 16'h0, 1'b0, 3'd0, 4'd15);
      check("model_sll", {pm.res, 8'h0, 4'(pm.lat), pm.szcv}, {16'h8000, 8'h0, 4'd0, 4'b1000});
      pm = model(4'd7, 16'h0100, 16'h0100, 1'b0, 3'd0, 4'd0);
      check("model_mul", {pm.res, 12'h0, pm.szcv}, {16'h0000, 12'h0, 4'b0110});

      send(4'b0000, 16'h7FFF, 16'h0001, 1'b0, 3'd0, 4'd0, acc);
      expect_out("add", acc, 1, 16'h8000, 4'b1001, 1'b1, 1'b0);
      send(4'b0001, 16'h0005, 16'h1234, 1'b1, 3'd5, 4'd0, acc);
      expect_out("sub_imm", acc, 1, 16'h0000, 4'b0110, 1'b1, 1'b0);
      send(4'b0101, 16'h0005, 16'h1234, 1'b1, 3'd5, 4'd0, acc);
      expect_out("cmp_imm", acc, 1, 16'h0000, 4'b0110, 1'b0, 1'b0);
      send(4'b1011, 16'h8001, 16'h0000, 1'b0, 3'd0, 4'd1, acc);
      expect_out("sra1", acc, 2, 16'hC000, 4'b1010, 1'b1, 1'b0);
      send(4'b1000, 16'h8001, 16'h0000, 1'b0, 3'd0, 4'd15, acc);
      expect_out("sll15", acc, 16, 16'h8000, 4'b1000, 1'b1, 1'b0);
      send(4'b0111, 16'h0100, 16'h0100, 1'b0, 3'd0, 4'd0, acc);
      expect_out("mul_ovf", acc, 17, 16'h0000, 4'b0110, 1'b1, 1'b0);
      send(4'b0111, 16'h0003, 16'h0005, 1'b0, 3'd0, 4'd0, acc);
      expect_out("mul_3x5", acc, 17, 16'h000F, 4'b0000, 1'b1, 1'b0);

      // Backpressure, then back-to-back accept on consumption
      ready_val = 1'b0;
      send(4'b0000, 16'h1234, 16'h1111, 1'b0, 3'd0, 4'd0, acc);
      expect_out("bp_add", acc, 1, 16'h2345, 4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold", {result, 12'h0, szcv}, {16'h2345, 16'h0000});
      end
      @(posedge clk); #1;
      ready_val = 1'b1;
      op = 4'b0100; a = 16'hFFFF; b = 16'h00FF; imm_en = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      check("b2b_old_valid", 32'(out_valid), 32'd1);
      acc = cycle;
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_out("b2b_xor", acc, 1, 16'hFF00, 4'b1000, 1'b1, 1'b0);

      // Reset during the third BUSY cycle of an SRL by 8
      send(4'b1010, 16'hF0F0, 16'h0000, 1'b0, 3'd0, 4'd8, acc);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_result", 32'(result), 32'd0);
      check("mid_rst_szcv", 32'(szcv), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      send(4'b1100, 16'h1234, 16'h5678, 1'b0, 3'd0, 4'd0, acc);
      expect_out("bad_op", acc, 1, 16'h0000, 4'b0100, 1'b0, 1'b1);

      // Randomized traffic with random consumer stalls
      ready_rand = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         ro = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0: ra = 16'hFFFF;
            1: ra = 16'h8000;
            2: ra = 16'h7FFF;
            default: ra = 16'($urandom);
         endcase
         send(ro, ra, 16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), acc);
         if ($urandom_range(0, 9) == 0) begin
            op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); shamt = 4'($urandom);
         end
      end
      ready_rand = 1'b0;
      ready_val  = 1'b1;
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      check("drain", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
